// File: rtl/cr_huf_comp_ph_mc.sv
// rtl/cr_huf_comp_ph_mc.sv - multi-channel predefined Huffman table store, 2-cycle read per channel
// Optional write-through forwarding at the RAM stage: CR_HUF_PH_WR_FWD_EN
module cr_huf_comp_ph_mc #(
  parameter int NUM_CH    = 4,
  parameter int NUM_SLOTS = 10,
  parameter int ENTRIES   = 48,
  parameter int DATA_W    = 60,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int ADDR_W    = $clog2(ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [SLOT_W-1:0]          wr_slot,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       inval,
  input  logic [SLOT_W-1:0]          inval_slot,
  output logic [NUM_SLOTS-1:0]       slot_vld,
  input  logic [NUM_CH-1:0]          rd_req,
  input  logic [NUM_CH*SLOT_W-1:0]   rd_slot,
  input  logic [NUM_CH*ADDR_W-1:0]   rd_addr,
  output logic [NUM_CH-1:0]          rsp_vld,
  output logic [NUM_CH*DATA_W-1:0]   rsp_data,
  output logic [NUM_CH-1:0]          rsp_err,
  output logic [15:0]                err_cnt
);
  localparam int DEPTH = NUM_SLOTS * ENTRIES;
  localparam int PA_W  = $clog2(DEPTH);
  localparam logic [SLOT_W:0]   SLOTS_C   = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [ADDR_W:0]   ENTRIES_C = (ADDR_W+1)'(ENTRIES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES-1);

  function automatic logic [PA_W-1:0] phys_addr(input logic [SLOT_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    return PA_W'(int'(s) * ENTRIES + int'(a));
  endfunction

  logic                 wr_ok;
  logic [PA_W-1:0]      wr_pa;
  logic [NUM_CH-1:0]    req_q, req_d;
  logic [SLOT_W-1:0]    slot_q [NUM_CH];
  logic [SLOT_W-1:0]    slot_d [NUM_CH];
  logic [ADDR_W-1:0]    addr_q [NUM_CH];
  logic [ADDR_W-1:0]    addr_d [NUM_CH];
  logic [PA_W-1:0]      rd_pa  [NUM_CH];
  logic [DATA_W-1:0]    ram_rd [NUM_CH];
  logic [NUM_CH-1:0]    rd_ok;
  logic [NUM_CH-1:0]    rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]    rsp_data_q [NUM_CH];
  logic [DATA_W-1:0]    rsp_data_d [NUM_CH];
  logic [NUM_SLOTS-1:0] slot_vld_q, slot_vld_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic [16:0]          err_sum;

  assign wr_ok = wr && ({1'b0, wr_slot} < SLOTS_C) && ({1'b0, wr_addr} < ENTRIES_C);
  assign wr_pa = phys_addr(wr_slot, wr_addr);

  // One replicated RAM per channel; every copy takes the same write.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_pa] <= wr_data;
    end
    assign rd_pa[c] = phys_addr(slot_q[c], addr_q[c]);
`ifdef CR_HUF_PH_WR_FWD_EN
    assign ram_rd[c] = (wr_ok && (wr_pa == rd_pa[c])) ? wr_data : mem[rd_pa[c]];
`else
    assign ram_rd[c] = mem[rd_pa[c]];
`endif
    assign rsp_data[c*DATA_W +: DATA_W] = rsp_data_q[c];
  end

  always_comb begin
    req_d      = rd_req;
    rsp_vld_d  = req_q;
    rsp_err_d  = '0;
    rd_ok      = '0;
    slot_vld_d = slot_vld_q;
    for (int c = 0; c < NUM_CH; c++) begin
      slot_d[c]     = rd_slot[c*SLOT_W +: SLOT_W];
      addr_d[c]     = rd_addr[c*ADDR_W +: ADDR_W];
      rsp_data_d[c] = rsp_data_q[c];
      rd_ok[c]      = ({1'b0, slot_q[c]} < SLOTS_C) && ({1'b0, addr_q[c]} < ENTRIES_C)
                      && slot_vld_q[slot_q[c]];
      if (req_q[c]) begin
        if (rd_ok[c]) begin
          rsp_data_d[c] = ram_rd[c];
        end else begin
          rsp_err_d[c]  = 1'b1;
          rsp_data_d[c] = '0;
        end
      end
    end
    // Set on last-entry write, inval applied afterwards so it wins on collision.
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wr_ok && (wr_addr == LAST_ADDR) && (wr_slot == SLOT_W'(s))) slot_vld_d[s] = 1'b1;
      if (inval && (inval_slot == SLOT_W'(s))) slot_vld_d[s] = 1'b0;
    end
    err_sum   = {1'b0, err_cnt_q} + 17'($countones(rsp_vld_q & rsp_err_q));
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_err_q  <= '0;
      slot_vld_q <= '0;
      err_cnt_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        slot_q[c]     <= '0;
        addr_q[c]     <= '0;
        rsp_data_q[c] <= '0;
      end
    end else begin
      req_q      <= req_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      slot_vld_q <= slot_vld_d;
      err_cnt_q  <= err_cnt_d;
      for (int c = 0; c < NUM_CH; c++) begin
        slot_q[c]     <= slot_d[c];
        addr_q[c]     <= addr_d[c];
        rsp_data_q[c] <= rsp_data_d[c];
      end
    end
  end

  assign rsp_vld  = rsp_vld_q;
  assign rsp_err  = rsp_err_q;
  assign slot_vld = slot_vld_q;
  assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_cr_huf_comp_ph_mc.sv
// tb/tb_cr_huf_comp_ph_mc.sv - bench for cr_huf_comp_ph_mc: directed table, corner sequences, random vs model
module tb_cr_huf_comp_ph_mc;
  localparam int NCH = 4, NS = 10, NE = 48, DW = 60, SW = 4, AW = 6;

  logic              clk = 1'b0;
  logic              rst, wr, inval;
  logic [SW-1:0]     wr_slot, inval_slot;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NS-1:0]     slot_vld;
  logic [NCH-1:0]    rd_req, rsp_vld, rsp_err;
  logic [NCH*SW-1:0] rd_slot;
  logic [NCH*AW-1:0] rd_addr;
  logic [NCH*DW-1:0] rsp_data;
  logic [15:0]       err_cnt;

  always #5 clk = ~clk;

  cr_huf_comp_ph_mc dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_slot(wr_slot), .wr_addr(wr_addr), .wr_data(wr_data),
    .inval(inval), .inval_slot(inval_slot), .slot_vld(slot_vld),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_addr(rd_addr),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: one logical table memory, pending request per channel.
  logic [DW-1:0]  m_mem [NS][NE];
  logic [NS-1:0]  m_vld = '0;
  logic [NCH-1:0] m_req = '0;
  int             m_slot [NCH];
  int             m_addr [NCH];
  logic [NCH-1:0] e_vld = '0, e_err = '0;
  logic [DW-1:0]  e_data [NCH];
  int             e_cnt = 0;

  function automatic logic [DW-1:0] ch_data(input int c);
    return rsp_data[c*DW +: DW];
  endfunction

  task automatic idle_inputs();
    rd_req = '0; wr = 1'b0; inval = 1'b0;
  endtask

  task automatic set_rd(input int c, input int s, input int a);
    rd_req[c] = 1'b1;
    rd_slot[c*SW +: SW] = SW'(s);
    rd_addr[c*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int s, input int a, input logic [DW-1:0] d);
    wr = 1'b1; wr_slot = SW'(s); wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic cycle();
    logic           c_rst, c_wr, c_inval, c_wok;
    int             c_ws, c_wa, c_is;
    logic [DW-1:0]  c_wd, d;
    logic [NCH-1:0] c_req;
    int             c_s [NCH];
    int             c_a [NCH];
    c_rst = rst; c_wr = wr; c_inval = inval; c_wd = wr_data;
    c_ws = int'(wr_slot); c_wa = int'(wr_addr); c_is = int'(inval_slot);
    c_req = rd_req;
    for (int c = 0; c < NCH; c++) begin
      c_s[c] = int'(rd_slot[c*SW +: SW]);
      c_a[c] = int'(rd_addr[c*AW +: AW]);
    end
    c_wok = c_wr && (c_ws < NS) && (c_wa < NE);
    @(posedge clk);
    if (c_rst) begin
      e_cnt = 0; e_vld = '0; e_err = '0; m_req = '0; m_vld = '0;
      for (int c = 0; c < NCH; c++) e_data[c] = '0;
    end else begin
      e_cnt = e_cnt + $countones(e_vld & e_err);
      if (e_cnt > 65535) e_cnt = 65535;
      for (int c = 0; c < NCH; c++) begin
        e_vld[c] = m_req[c];
        e_err[c] = 1'b0;
        if (m_req[c]) begin
          if (m_slot[c] < NS && m_addr[c] < NE && m_vld[m_slot[c]]) begin
            d = m_mem[m_slot[c]][m_addr[c]];
`ifdef CR_HUF_PH_WR_FWD_EN
            if (c_wok && c_ws == m_slot[c] && c_wa == m_addr[c]) d = c_wd;
`endif
            e_data[c] = d;
          end else begin
            e_err[c]  = 1'b1;
            e_data[c] = '0;
          end
        end
      end
      if (c_wok && c_wa == NE - 1) m_vld[c_ws] = 1'b1;
      if (c_inval && c_is < NS) m_vld[c_is] = 1'b0;
      m_req = c_req;
      for (int c = 0; c < NCH; c++) begin
        m_slot[c] = c_s[c];
        m_addr[c] = c_a[c];
      end
    end
    if (c_wok) m_mem[c_ws][c_wa] = c_wd;
    #1;
    check("model_rsp_vld", 64'(rsp_vld), 64'(e_vld));
    check("model_rsp_err", 64'(rsp_err), 64'(e_err));
    for (int c = 0; c < NCH; c++) check($sformatf("model_rsp_data_ch%0d", c), 64'(ch_data(c)), 64'(e_data[c]));
    check("model_slot_vld", 64'(slot_vld), 64'(m_vld));
    check("model_err_cnt", 64'(err_cnt), 64'(e_cnt));
  endtask

  typedef struct {
    int            ch;
    int            slot;
    int            addr;
    logic [DW-1:0] data;
    logic          err;
  } vec_t;

  vec_t tbl [7];
  logic exp_rst_vld [10];

  initial begin
    for (int s = 0; s < NS; s++) for (int a = 0; a < NE; a++) m_mem[s][a] = '0;
    for (int c = 0; c < NCH; c++) begin m_slot[c] = 0; m_addr[c] = 0; e_data[c] = '0; end
    tbl[0] = '{0, 3, 0,  60'h3000, 1'b0};
    tbl[1] = '{1, 3, 10, 60'h300A, 1'b0};
    tbl[2] = '{2, 3, 20, 60'h3014, 1'b0};
    tbl[3] = '{3, 3, 47, 60'h302F, 1'b0};
    tbl[4] = '{0, 5, 0,  60'h0,    1'b1};
    tbl[5] = '{1, 12, 0, 60'h0,    1'b1};
    tbl[6] = '{2, 3, 50, 60'h0,    1'b1};
    exp_rst_vld = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1};

    rst = 1'b1; idle_inputs();
    wr_slot = '0; wr_addr = '0; wr_data = '0; inval_slot = '0; rd_slot = '0; rd_addr = '0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    check("reset_rsp_vld", 64'(rsp_vld), 64'h0);
    check("reset_slot_vld", 64'(slot_vld), 64'h0);
    check("reset_err_cnt", 64'(err_cnt), 64'h0);
    check("reset_rsp_data", 64'(rsp_data[63:0]), 64'h0);

    for (int a = 0; a < NE; a++) begin
      set_wr(3, a, DW'(32'h3000 + a));
      cycle();
      if (a == NE - 2) check("fill_vld_before_last", 64'(slot_vld), 64'h0);
    end
    idle_inputs();
    check("fill_vld_after_last", 64'(slot_vld), 64'h008);

    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      set_rd(tbl[i].ch, tbl[i].slot, tbl[i].addr);
      cycle();
      idle_inputs();
      check($sformatf("tbl%0d_not_yet", i), 64'(rsp_vld), 64'h0);
      cycle();
      check($sformatf("tbl%0d_vld", i), 64'(rsp_vld), 64'(4'b1 << tbl[i].ch));
      check($sformatf("tbl%0d_err", i), 64'(rsp_err), 64'(tbl[i].err) << tbl[i].ch);
      check($sformatf("tbl%0d_data", i), 64'(ch_data(tbl[i].ch)), 64'(tbl[i].data));
      cycle();
    end
    cycle();
    check("tbl_err_cnt", 64'(err_cnt), 64'd3);

    set_rd(0, 3, 0); set_rd(1, 3, 10); set_rd(2, 3, 20); set_rd(3, 3, 47);
    cycle();
    idle_inputs();
    check("quad_not_yet", 64'(rsp_vld), 64'h0);
    cycle();
    check("quad_vld", 64'(rsp_vld), 64'hF);
    check("quad_err", 64'(rsp_err), 64'h0);
    check("quad_d0", 64'(ch_data(0)), 64'h3000);
    check("quad_d1", 64'(ch_data(1)), 64'h300A);
    check("quad_d2", 64'(ch_data(2)), 64'h3014);
    check("quad_d3", 64'(ch_data(3)), 64'h302F);
    cycle();

    set_wr(3, 47, 60'h302F); inval = 1'b1; inval_slot = 4'd3;
    cycle();
    idle_inputs();
    check("inval_wins", 64'(slot_vld), 64'h0);
    set_rd(0, 3, 0);
    cycle();
    idle_inputs();
    cycle();
    check("inval_read_err", 64'(rsp_err), 64'h1);
    check("inval_read_data", 64'(ch_data(0)), 64'h0);
    set_wr(3, 47, 60'h302F);
    cycle();
    idle_inputs();
    cycle();
    check("revalidate", 64'(slot_vld), 64'h008);

    set_rd(0, 3, 5);
    cycle();
    idle_inputs();
    set_wr(3, 5, 60'hABC);
    cycle();
    idle_inputs();
`ifdef CR_HUF_PH_WR_FWD_EN
    check("fwd_same_addr", 64'(ch_data(0)), 64'hABC);
`else
    check("fwd_same_addr", 64'(ch_data(0)), 64'h3005);
`endif
    set_rd(0, 3, 5);
    cycle();
    idle_inputs();
    cycle();
    check("after_write", 64'(ch_data(0)), 64'hABC);
    cycle();

    for (int k = 0; k < 10; k++) begin
      set_rd(1, 3, 1);
      rst = (k == 4);
      cycle();
      check($sformatf("rst_seq_k%0d", k), 64'(rsp_vld[1]), 64'(exp_rst_vld[k]));
    end
    rst = 1'b0; idle_inputs();
    cycle();
    check("rst_seq_drain", 64'(rsp_vld[1]), 64'h1);
    cycle();
    check("rst_seq_idle", 64'(rsp_vld[1]), 64'h0);

    for (int s = 0; s < NS; s++) begin
      for (int a = 0; a < NE; a++) begin
        set_wr(s, a, {$urandom, $urandom} & {DW{1'b1}});
        cycle();
      end
    end
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 1) == 1) set_rd(c, $urandom_range(0, 11), $urandom_range(0, 49));
      if ($urandom_range(0, 9) < 3)
        set_wr($urandom_range(0, 11), $urandom_range(0, 49), {$urandom, $urandom} & {DW{1'b1}});
      if ($urandom_range(0, 19) == 0) begin
        inval = 1'b1; inval_slot = SW'($urandom_range(0, 10));
      end
      cycle();
    end

    idle_inputs();
    for (int c = 0; c < NCH; c++) set_rd(c, 12, 0);
    for (int n = 0; n < 16400; n++) cycle();
    check("err_cnt_saturated", 64'(err_cnt), 64'hFFFF);
    cycle(); cycle();
    check("err_cnt_holds", 64'(err_cnt), 64'hFFFF);
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cr_huf_comp_ph_mc.md
Name: cr_huf_comp_ph_mc

Overview:
Parametrised multi-channel predefined-Huffman-table store for the Huffman compressor. Holds NUM_SLOTS predefined tables of ENTRIES words each. One write port is loaded by the sequencer, and NUM_CH independent read channels serve the Huffman writers. One replicated RAM per channel gives one read per channel per cycle. Beyond the fixed 4-channel predecessor, it adds per-slot table-valid tracking, range/validity error responses and a saturating error counter.

Parameters:
NUM_CH, 4, number of independent read channels (1..8)
NUM_SLOTS, 10, number of predefined tables
ENTRIES, 48, words per table
DATA_W, 60, table word width
SLOT_W, $clog2(NUM_SLOTS), slot index width (derived)
ADDR_W, $clog2(ENTRIES), in-table address width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr  in  1  write strobe
wr_slot  in  SLOT_W  table slot being written
wr_addr  in  ADDR_W  entry within slot
wr_data  in  DATA_W  entry data
inval  in  1  invalidate-slot strobe
inval_slot  in  SLOT_W  slot to invalidate
slot_vld  out  NUM_SLOTS  per-slot table-complete flags
rd_req  in  NUM_CH  per-channel read request
rd_slot  in  NUM_CH*SLOT_W  per-channel slot, channel c at [c*SLOT_W +: SLOT_W]
rd_addr  in  NUM_CH*ADDR_W  per-channel entry address
rsp_vld  out  NUM_CH  per-channel response valid
rsp_data  out  NUM_CH*DATA_W  per-channel response data
rsp_err  out  NUM_CH  per-channel response error
err_cnt  out  16  saturating count of error responses

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high and sampled on the clk rising edge.
- Reset: all outputs return to 0 (rsp_vld, rsp_data, rsp_err, slot_vld, err_cnt). Stage-1 request flops clear. RAM contents are not cleared. Reset mid-read drops every in-flight response; no rsp_vld follows reset.
- Storage: NUM_CH RAMs, each NUM_SLOTS*ENTRIES x DATA_W. Physical address = slot*ENTRIES + addr, with width $clog2(NUM_SLOTS*ENTRIES).
- Write path: wr writes all NUM_CH RAMs at the same physical address in the same cycle.
  - A write with wr_slot >= NUM_SLOTS or wr_addr >= ENTRIES is dropped silently.
- slot_vld[s]:
  - Set the cycle after a write to slot s at addr ENTRIES-1.
  - Cleared the cycle after inval with inval_slot==s.
  - If both hit the same slot in one cycle, inval wins and the bit clears.
  - inval has no effect on RAM contents.
- Read pipeline, per channel, fixed 2-cycle latency:
  - Cycle N: rd_req, rd_slot and rd_addr are registered (stage 1).
  - Cycle N+1: RAM read from the registered address, with the error check evaluated against slot_vld at N+1.
  - Cycle N+2: rsp_vld=1 with rsp_data and rsp_err from the output flop.
  - Back-to-back requests every cycle give back-to-back responses in order. No backpressure exists.
- Error rule: a stage-1 request with slot >= NUM_SLOTS, addr >= ENTRIES, or slot_vld[slot]==0 does not enable the RAM. Its response is rsp_err=1 and rsp_data=0.
- rsp_data when rsp_vld=0: holds its last value. rsp_err is 0 whenever rsp_vld=0.
- err_cnt: increments by popcount(rsp_vld & rsp_err) each cycle. It saturates at 16'hFFFF and never wraps.
- Write/read same address, same cycle (write in N+1 with the read at its RAM stage): the read returns old RAM data, unless the optional feature below is compiled in.
- Channels are fully independent. Any mix of rd_req bits may be set each cycle.

Optional Feature:
CR_HUF_PH_WR_FWD_EN
- Defined: a read whose RAM stage coincides with an in-range write to the same physical address returns wr_data, i.e. write-through forwarding.
- Undefined: the read returns the pre-write RAM content. No forwarding mux is built.

Test Plan:
- Reset, then fill slot 3 (48 writes, data = 0x3000+addr): slot_vld[3] rises the cycle after the addr-47 write, and slot_vld stays 0 elsewhere.
- All 4 channels read slot 3 addr 0,10,20,47 in one cycle: rsp_vld=4'hF exactly 2 cycles later, data 0x3000, 0x300A, 0x3014, 0x302F, rsp_err=0.
- Read slot 5 (never written), slot 12, and slot 3 addr 50: rsp_err=1 and rsp_data=0 on each response; err_cnt=3.
- Same cycle: write slot 3 addr 47 and inval slot 3: slot_vld[3]=0. A subsequent read of slot 3 returns err.
- Write 0xABC to slot 3 addr 5 coinciding with a ch0 RAM-stage read of the same address: old data without CR_HUF_PH_WR_FWD_EN, 0xABC with it.
- Continuous requests on ch1 for 10 cycles with rst asserted at cycle 4: rsp_vld stays 0 from the cycle after rst and during it. The pipeline resumes with 2-cycle latency after rst deasserts.
